// File: rtl/barrel_rotator.sv
// barrel_rotator: log2(PORT_NUM)-stage pipelined port rotator with valid/ready flow control.
// Ports: clk, rst_n (async, active-low), flush (sync clear); in_valid/in_ready/in_sel/in_dir/in_data
// upstream; out_valid/out_ready/out_data downstream; beat_cnt only with BARREL_ROTATOR_BEAT_CNT_EN.
module barrel_rotator #(
  parameter int PORT_NUM = 8,
  parameter int PORT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(PORT_NUM)-1:0]   in_sel,
  input  logic                          in_dir,
  input  logic [PORT_NUM*PORT_W-1:0]    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PORT_NUM*PORT_W-1:0]    out_data
`ifdef BARREL_ROTATOR_BEAT_CNT_EN
  ,
  output logic [15:0]                   beat_cnt
`endif
);

  localparam int SEL_W = $clog2(PORT_NUM);
  localparam int S     = SEL_W;
  localparam int DW    = PORT_NUM * PORT_W;

  // Port index arithmetic is done in SEL_W bits so it wraps mod PORT_NUM.
  function automatic logic [DW-1:0] f_rot(
    input logic [DW-1:0]    d,
    input logic [SEL_W-1:0] amt,
    input logic             dn
  );
    logic [SEL_W-1:0] src;
    f_rot = '0;
    for (int j = 0; j < PORT_NUM; j++) begin
      src = dn ? SEL_W'(j) + amt : SEL_W'(j) - amt;
      f_rot[j*PORT_W +: PORT_W] = d[src*PORT_W +: PORT_W];
    end
  endfunction

  logic             r_valid [S];
  logic [DW-1:0]    r_data  [S];
  logic [SEL_W-1:0] r_sel   [S];
  logic             r_dir   [S];

  logic             w_pv    [S];
  logic [DW-1:0]    w_pd    [S];
  logic [SEL_W-1:0] w_ps    [S];
  logic             w_pdir  [S];
  logic [DW-1:0]    w_rot   [S];
  logic             w_ready [S];

  always_comb begin
    for (int k = 0; k < S; k++) begin
      if (k == 0) begin
        w_pv[k]   = in_valid;
        w_pd[k]   = in_data;
        w_ps[k]   = in_sel;
        w_pdir[k] = in_dir;
      end else begin
        w_pv[k]   = r_valid[k-1];
        w_pd[k]   = r_data[k-1];
        w_ps[k]   = r_sel[k-1];
        w_pdir[k] = r_dir[k-1];
      end
      w_rot[k] = w_ps[k][k]
               ? f_rot(w_pd[k], SEL_W'(1 << k), w_pdir[k])
               : w_pd[k];
      // Unrolled ready chain: a stage can load if any
      // stage at or after it is empty, or the sink takes.
      w_ready[k] = out_ready;
      for (int m = k; m < S; m++) begin
        if (!r_valid[m]) w_ready[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_sel[k]   <= '0;
        r_dir[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_ready[k]) begin
          r_valid[k] <= w_pv[k];
          if (w_pv[k]) begin
            r_data[k] <= w_rot[k];
            r_sel[k]  <= w_ps[k];
            r_dir[k]  <= w_pdir[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[0] && !flush;
  assign out_valid = r_valid[S-1];
  assign out_data  = r_data[S-1];

`ifdef BARREL_ROTATOR_BEAT_CNT_EN
  logic [15:0] r_beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (flush) begin
      r_beat_cnt <= '0;
    end else if (out_valid && out_ready
                 && r_beat_cnt != 16'hFFFF) begin
      r_beat_cnt <= r_beat_cnt + 16'd1;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_barrel_rotator.sv
// tb_barrel_rotator: scoreboard bench for barrel_rotator (8 ports x 16 bits).
// Random and directed beats; expected words come from an index-arithmetic model.
module tb_barrel_rotator;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int S  = 3;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_dir = 1'b0;
  logic          out_ready = 1'b0;
  logic [S-1:0]  in_sel = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
`ifdef BARREL_ROTATOR_BEAT_CNT_EN
  logic [15:0]   beat_cnt;
`endif

  barrel_rotator #(.PORT_NUM(N), .PORT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_dir    (in_dir),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BARREL_ROTATOR_BEAT_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cnt_exp = 0;
  bit   lat_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Output port j reads input port (j -/+ sel) mod N.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] d,
                                          input int sel,
                                          input bit dir);
    logic [DW-1:0] r;
    int src;
    r = '0;
    for (int j = 0; j < N; j++) begin
      src = dir ? (j + sel) % N : (j - sel + N) % N;
      r[j*W +: W] = d[src*W +: W];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] seq_data();
    logic [DW-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = W'(j);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic step(input bit v, input int sel, input bit dir,
                      input logic [DW-1:0] d,
                      input bit ordy, input bit fl);
    exp_t e;
    bit   exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_sel    = S'(sel);
    in_dir    = dir;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    // Occupancy equals beats accepted but not yet delivered.
    exp_rdy = !fl && (ordy || q.size() < S);
    chk("in_ready", DW'(in_ready), DW'(exp_rdy));
    if (v && in_ready) begin
      e.d   = model(d, sel, dir);
      e.acc = cyc;
      e.lat = lat_on;
      q.push_back(e);
    end
    if (fl) q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", DW'(in_ready), DW'(1));
  endtask

  initial begin : monitor
    logic [DW-1:0] hd;
    bit            hv;
    exp_t          e;
    hv = 1'b0;
    hd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hv = 1'b0;
        cnt_exp = 0;
        continue;
      end
      if (hv) begin
        chk("stall_valid", DW'(out_valid), DW'(1));
        chk("stall_data", out_data, hd);
      end
`ifdef BARREL_ROTATOR_BEAT_CNT_EN
      chk("beat_cnt", DW'(beat_cnt), DW'(cnt_exp));
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: got beat %h expected none",
                   out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          if (e.lat) chk("latency", DW'(cyc - e.acc), DW'(S));
        end
      end
      hv = out_valid && !out_ready && !flush;
      hd = out_data;
      if (flush) cnt_exp = 0;
      else if (out_valid && out_ready && cnt_exp < 65535)
        cnt_exp++;
    end
  end

  initial begin : driver
    bit fl;
    bit ordy;
    #1;
    chk("reset_out_valid", DW'(out_valid), DW'(0));
    chk("reset_out_data", out_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", DW'(in_ready), DW'(1));

    // sel=3 up: latency and fixed-pattern rotation
    lat_on = 1'b1;
    step(1'b1, 3, 1'b0, seq_data(), 1'b1, 1'b0);
    idle(4);

    // sel=1 down, then identity both directions
    step(1'b1, 1, 1'b1, seq_data(), 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, seq_data(), 1'b1, 1'b0);
    step(1'b1, 0, 1'b1, rnd_data(), 1'b1, 1'b0);
    idle(4);

    // clear the counter, then 8 back-to-back beats
    step(1'b0, 0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b1, i, i[0], rnd_data(), 1'b1, 1'b0);
    idle(4);
`ifdef BARREL_ROTATOR_BEAT_CNT_EN
    chk("beat_cnt_8", DW'(beat_cnt), DW'(8));
`endif
    lat_on = 1'b0;

    // stall for 6 cycles mid-stream
    for (int i = 0; i < 14; i++)
      step(1'b1, int'($urandom_range(7)), bit'($urandom_range(1)),
           rnd_data(), !(i >= 2 && i < 8), 1'b0);
    idle(6);

    // flush with 3 beats in flight and in_valid high
    for (int i = 0; i < 3; i++)
      step(1'b1, i + 2, 1'b0, rnd_data(), 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, rnd_data(), 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    chk("flush_out_valid", DW'(out_valid), DW'(0));
`ifdef BARREL_ROTATOR_BEAT_CNT_EN
    chk("flush_beat_cnt", DW'(beat_cnt), DW'(0));
`endif
    idle(4);

    // reset pulse while a stream is in flight
    for (int i = 0; i < 4; i++)
      step(1'b1, i, 1'b1, rnd_data(), 1'b1, 1'b0);
    do_reset();
    idle(6);

    // random traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      fl   = ($urandom_range(49) == 0);
      ordy = fl ? 1'b0 : ($urandom_range(3) != 0);
      step($urandom_range(3) != 0, int'($urandom_range(7)),
           bit'($urandom_range(1)), rnd_data(), ordy, fl);
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) idle(1);
    idle(2);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats pending expected 0",
               q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
